// File: rtl/graying_pkg.sv
// Shared constants and types for the RGB-to-grey converter:
// BT.601 fixed-point weights, mode encodings and the request/acknowledge FSM states.
package graying_pkg;

  localparam logic [7:0] W_R = 8'd77;
  localparam logic [7:0] W_G = 8'd150;
  localparam logic [7:0] W_B = 8'd29;
  localparam int GRAY_SHIFT = 8;

  localparam int MODE_PIPE   = 0;
  localparam int MODE_REQACK = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } gray_state_e;

endpackage

// File: rtl/graying_calc.sv
// Pipelined weighted sum Y = (77R + 150G + 29B) >> 8 with a valid bit travelling
// alongside the data: product register, mul_delay extra stages, then sum/shift register.
module graying_calc
  import graying_pkg::*;
#(
  parameter int color_width = 8,
  parameter int mul_delay   = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [3*color_width-1:0] in_data,
  output logic                     out_valid,
  output logic [color_width-1:0]   out_data
);

  localparam int PW = color_width + 8;
  localparam int SW = color_width + 10;

  logic [color_width-1:0] red_s;
  logic [color_width-1:0] green_s;
  logic [color_width-1:0] blue_s;
  logic [PW-1:0]          r_prod_r [0:mul_delay];
  logic [PW-1:0]          g_prod_r [0:mul_delay];
  logic [PW-1:0]          b_prod_r [0:mul_delay];
  logic [mul_delay:0]     vld_r;
  logic [SW-1:0]          sum_s;
  logic                   valid_r;
  logic [color_width-1:0] data_r;
  logic                   unused_sum_bits_s;

  function automatic logic [PW-1:0] weigh(input logic [color_width-1:0] chan,
                                          input logic [7:0] weight);
    return PW'(chan) * PW'(weight);
  endfunction

  assign red_s   = in_data[3*color_width-1 -: color_width];
  assign green_s = in_data[2*color_width-1 -: color_width];
  assign blue_s  = in_data[color_width-1 -: color_width];

  // Product register followed by the optional delay stages.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i <= mul_delay; i++) begin
        r_prod_r[i] <= {PW{1'b0}};
        g_prod_r[i] <= {PW{1'b0}};
        b_prod_r[i] <= {PW{1'b0}};
        vld_r[i]    <= 1'b0;
      end
    end else begin
      r_prod_r[0] <= weigh(red_s, W_R);
      g_prod_r[0] <= weigh(green_s, W_G);
      b_prod_r[0] <= weigh(blue_s, W_B);
      vld_r[0]    <= in_valid;
      for (int i = 1; i <= mul_delay; i++) begin
        r_prod_r[i] <= r_prod_r[i-1];
        g_prod_r[i] <= g_prod_r[i-1];
        b_prod_r[i] <= b_prod_r[i-1];
        vld_r[i]    <= vld_r[i-1];
      end
    end
  end

  // Weights add up to 256, so the shifted sum always fits color_width bits.
  always_comb begin
    sum_s = SW'(r_prod_r[mul_delay]) + SW'(g_prod_r[mul_delay]) + SW'(b_prod_r[mul_delay]);
  end

  assign unused_sum_bits_s = ^{sum_s[SW-1:GRAY_SHIFT+color_width], sum_s[GRAY_SHIFT-1:0]};

  // Output register; data holds its last value across bubbles.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      valid_r <= 1'b0;
      data_r  <= {color_width{1'b0}};
    end else begin
      valid_r <= vld_r[mul_delay];
      if (vld_r[mul_delay]) begin
        data_r <= sum_s[GRAY_SHIFT +: color_width];
      end else begin
        data_r <= data_r;
      end
    end
  end

  assign out_valid = valid_r;
  assign out_data  = data_r;

endmodule

// File: rtl/graying.sv
// RGB-to-grey point operation. work_mode 0 streams one pixel per clock through the
// calculation pipeline; work_mode 1 wraps it in a request/acknowledge FSM.
module graying
  import graying_pkg::*;
#(
  parameter int work_mode   = 0,
  parameter int color_width = 8,
  parameter int mul_delay   = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_enable,
  input  logic [3*color_width-1:0] in_data,
  output logic                     out_ready,
  output logic [color_width-1:0]   out_data
);

  localparam int LAT = 2 + mul_delay;

  logic                   calc_in_vld_s;
  logic                   calc_vld_s;
  logic [color_width-1:0] calc_data_s;

  graying_calc #(
    .color_width(color_width),
    .mul_delay  (mul_delay)
  ) u_calc (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (calc_in_vld_s),
    .in_data  (in_data),
    .out_valid(calc_vld_s),
    .out_data (calc_data_s)
  );

  generate
    if (work_mode == MODE_PIPE) begin : g_pipe
      assign calc_in_vld_s = in_enable;
      assign out_ready     = calc_vld_s;
      assign out_data      = calc_data_s;
    end else begin : g_reqack
      localparam logic [3:0] LAST_CNT = 4'(LAT - 1);

      gray_state_e            state_r;
      gray_state_e            state_s;
      logic [3:0]             cnt_r;
      logic [3:0]             cnt_s;
      logic                   rdy_r;
      logic                   rdy_s;
      logic [color_width-1:0] data_r;
      logic [color_width-1:0] data_s;

      // Next-state logic; the calc pipeline captures the pixel on the request edge.
      always_comb begin
        state_s       = state_r;
        cnt_s         = cnt_r;
        rdy_s         = rdy_r;
        data_s        = data_r;
        calc_in_vld_s = 1'b0;
        case (state_r)
          IDLE: begin
            rdy_s = 1'b0;
            if (in_enable) begin
              calc_in_vld_s = 1'b1;
              cnt_s         = 4'd0;
              state_s       = CALC;
            end else begin
              state_s = IDLE;
            end
          end
          CALC: begin
            if (!in_enable) begin
              state_s = IDLE;
            end else if ((cnt_r == LAST_CNT) && calc_vld_s) begin
              data_s  = calc_data_s;
              rdy_s   = 1'b1;
              state_s = DONE;
            end else begin
              cnt_s = cnt_r + 4'd1;
            end
          end
          DONE: begin
            if (!in_enable) begin
              rdy_s   = 1'b0;
              state_s = IDLE;
            end else begin
              rdy_s = 1'b1;
            end
          end
          default: begin
            rdy_s   = 1'b0;
            state_s = IDLE;
          end
        endcase
      end

      // FSM and output registers.
      always_ff @(posedge clk) begin
        if (rst_n) begin
          state_r <= IDLE;
          cnt_r   <= 4'd0;
          rdy_r   <= 1'b0;
          data_r  <= {color_width{1'b0}};
        end else begin
          state_r <= state_s;
          cnt_r   <= cnt_s;
          rdy_r   <= rdy_s;
          data_r  <= data_s;
        end
      end

      assign out_ready = rdy_r;
      assign out_data  = data_r;
    end
  endgenerate

endmodule

// File: tb/tb_graying.sv
// Self-checking bench for graying: four instances (pipeline / req-ack, mul_delay 0 / 3),
// directed table and sequences plus randomized traffic against a transaction-level model.
interface TBInterface #(parameter int color_width = 8) (input logic clk);
  logic                     rst_n;
  logic                     in_enable;
  logic [3*color_width-1:0] in_data;
  logic                     out_ready;
  logic [color_width-1:0]   out_data;
endinterface

module tb_graying;

  localparam int CW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  TBInterface #(.color_width(CW)) if_p0 (clk);
  TBInterface #(.color_width(CW)) if_p3 (clk);
  TBInterface #(.color_width(CW)) if_r0 (clk);
  TBInterface #(.color_width(CW)) if_r3 (clk);

  graying #(.work_mode(0), .color_width(CW), .mul_delay(0)) u_p0 (
    .clk(if_p0.clk), .rst_n(if_p0.rst_n), .in_enable(if_p0.in_enable),
    .in_data(if_p0.in_data), .out_ready(if_p0.out_ready), .out_data(if_p0.out_data));
  graying #(.work_mode(0), .color_width(CW), .mul_delay(3)) u_p3 (
    .clk(if_p3.clk), .rst_n(if_p3.rst_n), .in_enable(if_p3.in_enable),
    .in_data(if_p3.in_data), .out_ready(if_p3.out_ready), .out_data(if_p3.out_data));
  graying #(.work_mode(1), .color_width(CW), .mul_delay(0)) u_r0 (
    .clk(if_r0.clk), .rst_n(if_r0.rst_n), .in_enable(if_r0.in_enable),
    .in_data(if_r0.in_data), .out_ready(if_r0.out_ready), .out_data(if_r0.out_data));
  graying #(.work_mode(1), .color_width(CW), .mul_delay(3)) u_r3 (
    .clk(if_r3.clk), .rst_n(if_r3.rst_n), .in_enable(if_r3.in_enable),
    .in_data(if_r3.in_data), .out_ready(if_r3.out_ready), .out_data(if_r3.out_data));

  typedef struct {
    logic       en;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       exp_rdy;
    logic [7:0] exp_data;
  } vec_t;

  localparam int NRAND = 200;

  vec_t        tbl [10];
  int          n_cmp  = 0;
  int          n_fail = 0;
  int          cnt;
  int          lat0;
  int          lat3;
  int          lat_of [2];
  logic [7:0]  last [2];
  logic        en_h [NRAND];
  logic [23:0] px_h [NRAND];
  logic [23:0] px;
  logic        en;
  int          hold;
  int          gap;

  // Reference: BT.601 fixed-point luminance computed with plain integer arithmetic.
  function automatic logic [7:0] luma(input logic [23:0] p);
    int r;
    int g;
    int b;
    r = int'(p[23:16]);
    g = int'(p[15:8]);
    b = int'(p[7:0]);
    return 8'((77 * r + 150 * g + 29 * b) / 256);
  endfunction

  function automatic logic r_rdy(input int d);
    return (d == 0) ? if_r0.out_ready : if_r3.out_ready;
  endfunction

  function automatic logic [7:0] r_dat(input int d);
    return (d == 0) ? if_r0.out_data : if_r3.out_data;
  endfunction

  function automatic logic p_rdy(input int d);
    return (d == 0) ? if_p0.out_ready : if_p3.out_ready;
  endfunction

  function automatic logic [7:0] p_dat(input int d);
    return (d == 0) ? if_p0.out_data : if_p3.out_data;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_p(input logic e, input logic [23:0] d);
    if_p0.in_enable = e; if_p0.in_data = d;
    if_p3.in_enable = e; if_p3.in_data = d;
  endtask

  task automatic set_r(input logic e, input logic [23:0] d);
    if_r0.in_enable = e; if_r0.in_data = d;
    if_r3.in_enable = e; if_r3.in_data = d;
  endtask

  task automatic rst_p(input int n);
    if_p0.rst_n = 1'b1; if_p3.rst_n = 1'b1;
    set_p(1'b0, 24'd0);
    repeat (n) tick();
    if_p0.rst_n = 1'b0; if_p3.rst_n = 1'b0;
  endtask

  task automatic rst_r(input int n);
    if_r0.rst_n = 1'b1; if_r3.rst_n = 1'b1;
    set_r(1'b0, 24'd0);
    repeat (n) tick();
    if_r0.rst_n = 1'b0; if_r3.rst_n = 1'b0;
  endtask

  // Ticks until the chosen req/ack instance acknowledges, bounded by budget.
  task automatic req_latency(input int d, input int budget, output int c);
    c = 0;
    do begin
      tick();
      c++;
    end while (!r_rdy(d) && c < budget);
  endtask

  initial begin
    tbl[0] = '{1'b1, 8'd255, 8'd255, 8'd255, 1'b0, 8'd0};
    tbl[1] = '{1'b1, 8'd255, 8'd0,   8'd0,   1'b1, 8'd255};
    tbl[2] = '{1'b1, 8'd0,   8'd255, 8'd0,   1'b1, 8'd76};
    tbl[3] = '{1'b1, 8'd0,   8'd0,   8'd255, 1'b1, 8'd149};
    tbl[4] = '{1'b1, 8'd100, 8'd150, 8'd200, 1'b1, 8'd28};
    tbl[5] = '{1'b0, 8'd0,   8'd0,   8'd0,   1'b1, 8'd140};
    tbl[6] = '{1'b0, 8'd0,   8'd0,   8'd0,   1'b0, 8'd140};
    tbl[7] = '{1'b1, 8'd0,   8'd0,   8'd0,   1'b0, 8'd140};
    tbl[8] = '{1'b0, 8'd0,   8'd0,   8'd0,   1'b1, 8'd0};
    tbl[9] = '{1'b0, 8'd0,   8'd0,   8'd0,   1'b0, 8'd0};

    // Power-on reset of every instance, outputs must read zero throughout.
    if_p0.rst_n = 1'b1; if_p3.rst_n = 1'b1; if_r0.rst_n = 1'b1; if_r3.rst_n = 1'b1;
    set_p(1'b0, 24'd0);
    set_r(1'b0, 24'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("reset_p0_ready", if_p0.out_ready, 1'b0);
      chk("reset_r0_data", if_r0.out_data, 8'd0);
    end
    if_p0.rst_n = 1'b0; if_p3.rst_n = 1'b0; if_r0.rst_n = 1'b0; if_r3.rst_n = 1'b0;

    // Mode 0 directed stream with bubbles.
    for (int i = 0; i < 10; i++) begin
      set_p(tbl[i].en, {tbl[i].r, tbl[i].g, tbl[i].b});
      tick();
      chk($sformatf("table_ready[%0d]", i), if_p0.out_ready, tbl[i].exp_rdy);
      chk($sformatf("table_data[%0d]", i), if_p0.out_data, tbl[i].exp_data);
    end

    // Mode 0 latency: mul_delay=3 must trail mul_delay=0 by exactly three cycles.
    rst_p(1);
    set_p(1'b1, {8'd100, 8'd150, 8'd200});
    tick();
    set_p(1'b0, 24'd0);
    lat0 = -1;
    lat3 = -1;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) tick();
      if (lat0 < 0 && if_p0.out_ready) lat0 = k;
      if (lat3 < 0 && if_p3.out_ready) lat3 = k;
    end
    chk("p0_latency", lat0, 1);
    chk("p3_latency", lat3, 4);
    chk("p3_data", if_p3.out_data, 8'd140);

    // Mode 0 reset mid-stream: outputs clear and nothing stale emerges afterwards.
    set_p(1'b1, 24'hFFFFFF);
    repeat (3) tick();
    if_p0.rst_n = 1'b1; if_p3.rst_n = 1'b1;
    tick();
    chk("p0_midrst_ready", if_p0.out_ready, 1'b0);
    chk("p0_midrst_data", if_p0.out_data, 8'd0);
    chk("p3_midrst_ready", if_p3.out_ready, 1'b0);
    if_p0.rst_n = 1'b0; if_p3.rst_n = 1'b0;
    set_p(1'b0, 24'd0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("p0_postrst_ready", if_p0.out_ready, 1'b0);
      chk("p3_postrst_data", if_p3.out_data, 8'd0);
    end

    // Mode 0 random traffic against the history model.
    rst_p(1);
    lat_of[0] = 2;
    lat_of[1] = 5;
    last[0] = 8'd0;
    last[1] = 8'd0;
    for (int k = 0; k < NRAND; k++) begin
      en = ($urandom_range(0, 3) != 0);
      px = 24'($urandom);
      en_h[k] = en;
      px_h[k] = px;
      set_p(en, px);
      tick();
      for (int d = 0; d < 2; d++) begin
        int  idx;
        logic er;
        idx = k - lat_of[d] + 1;
        er  = (idx >= 0) ? en_h[(idx >= 0) ? idx : 0] : 1'b0;
        if (er) last[d] = luma(px_h[idx]);
        chk($sformatf("rand_p%0d_ready", d), p_rdy(d), er);
        chk($sformatf("rand_p%0d_data", d), p_dat(d), last[d]);
      end
    end

    // Mode 1: held request, input changed during CALC, then release.
    rst_r(2);
    set_r(1'b1, {8'd100, 8'd150, 8'd200});
    tick();
    chk("r0_calc_ready", if_r0.out_ready, 1'b0);
    set_r(1'b1, 24'hFFFFFF);
    req_latency(0, 20, cnt);
    chk("r0_latency", cnt + 1, 3);
    chk("r0_data", if_r0.out_data, 8'd140);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("r0_hold_ready", if_r0.out_ready, 1'b1);
      chk("r0_hold_data", if_r0.out_data, 8'd140);
    end
    set_r(1'b0, 24'd0);
    tick();
    chk("r0_release_ready", if_r0.out_ready, 1'b0);
    chk("r0_release_data", if_r0.out_data, 8'd140);
    set_r(1'b1, 24'hFFFFFF);
    req_latency(0, 20, cnt);
    chk("r0_second_latency", cnt, 3);
    chk("r0_second_data", if_r0.out_data, 8'd255);

    // Mode 1 abort mid-CALC, then a normal request proves the FSM is idle again.
    set_r(1'b0, 24'd0);
    tick();
    set_r(1'b1, {8'd100, 8'd150, 8'd200});
    tick();
    set_r(1'b0, 24'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("r0_abort_ready", if_r0.out_ready, 1'b0);
      chk("r0_abort_data", if_r0.out_data, 8'd255);
    end
    set_r(1'b1, {8'd0, 8'd255, 8'd0});
    req_latency(0, 20, cnt);
    chk("r0_after_abort_latency", cnt, 3);
    chk("r0_after_abort_data", if_r0.out_data, 8'd149);

    // Mode 1 reset mid-CALC.
    set_r(1'b0, 24'd0);
    tick();
    set_r(1'b1, 24'hFFFFFF);
    tick();
    if_r0.rst_n = 1'b1; if_r3.rst_n = 1'b1;
    tick();
    chk("r0_midrst_ready", if_r0.out_ready, 1'b0);
    chk("r0_midrst_data", if_r0.out_data, 8'd0);
    if_r0.rst_n = 1'b0; if_r3.rst_n = 1'b0;
    set_r(1'b0, 24'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("r0_postrst_ready", if_r0.out_ready, 1'b0);
      chk("r0_postrst_data", if_r0.out_data, 8'd0);
    end

    // Mode 1 with mul_delay=3.
    rst_r(1);
    set_r(1'b1, {8'd0, 8'd0, 8'd255});
    req_latency(1, 20, cnt);
    chk("r3_latency", cnt, 6);
    chk("r3_data", if_r3.out_data, 8'd28);

    // Mode 1 random transactions: hold for hold edges, then gap low edges.
    rst_r(1);
    last[0] = 8'd0;
    last[1] = 8'd0;
    lat_of[0] = 2;
    lat_of[1] = 5;
    for (int t = 0; t < 40; t++) begin
      hold = $urandom_range(1, 10);
      gap  = $urandom_range(1, 3);
      px   = 24'($urandom);
      for (int j = 0; j < hold + gap; j++) begin
        if (j == 0) set_r(1'b1, px);
        else        set_r(j < hold, 24'($urandom));
        tick();
        for (int d = 0; d < 2; d++) begin
          logic er;
          er = (hold >= lat_of[d] + 1) && (j >= lat_of[d]) && (j <= hold - 1);
          if (er) last[d] = luma(px);
          chk($sformatf("rand_r%0d_ready", d), r_rdy(d), er);
          chk($sformatf("rand_r%0d_data", d), r_dat(d), last[d]);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/graying.md
Name: graying

Overview:
- Converts one packed RGB pixel per transaction into an 8-bit-class luminance (grey) value using fixed-point BT.601 weights.
- Point-operation stage in the image pipeline.
- A parameter selects between two modes:
  - streaming pipeline mode, one pixel per clock;
  - request/acknowledge mode, one pixel per handshake.

Parameters:
- work_mode, 0, 0 = pipeline mode; 1 = request/acknowledge mode.
- color_width, 8, bits per colour channel and width of out_data; legal range 1..15.
- mul_delay, 0, extra register stages inserted after the multiply stage; legal range 0..7.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous reset, active-high: asserted when 1, sampled on the rising edge of clk.
- in_enable  input  1  mode 0: input-valid strobe; mode 1: request, held until acknowledged.
- in_data  input  3*color_width  packed pixel: [3cw-1:2cw]=R, [2cw-1:cw]=G, [cw-1:0]=B.
- out_ready  output  1  mode 0: out_data valid this cycle; mode 1: acknowledge / result valid.
- out_data  output  color_width  grey result.

Behaviour:
- Arithmetic:
  - Y = (77*R + 150*G + 29*B) >> 8.
  - Products are cw+8 bits; the sum is cw+10 bits; the result is truncated to cw bits.
  - The weights sum to 256, so no saturation is needed (max input gives max output).
  - Rounding is truncation toward zero.
- Latency: L = 2 + mul_delay register stages (products register, then mul_delay stages, then sum/shift register).
- Reset (rst_n=1 at a rising edge): out_ready=0, out_data=0, all pipeline valid bits and data registers cleared, FSM to IDLE. Reset has priority over everything and aborts any transaction in flight.
- Mode 0 (pipeline):
  - in_data is sampled at every rising edge where in_enable=1.
  - A valid bit travels with the data through L stages.
  - A pixel sampled at edge n drives out_data, with out_ready=1, after edge n+L-1.
  - Back-to-back input: one result per cycle, in order, no bubbles.
  - in_enable=0 inserts a bubble: out_ready=0 for that slot L cycles later. out_data holds its last value during bubbles.
  - No backpressure; the consumer must accept every result.
- Mode 1 (req/ack), FSM states IDLE, CALC, DONE:
  - IDLE: out_ready=0. If in_enable=1, latch in_data, go to CALC and start a cycle counter.
  - CALC: after L cycles, out_data = result, out_ready=1, go to DONE. If in_enable falls during CALC, abort to IDLE and leave out_data unchanged.
  - DONE: hold out_data and out_ready=1 while in_enable=1. When in_enable=0, clear out_ready at the next edge and go to IDLE.
  - A new request needs in_enable low for at least one sampled edge. A continuously high in_enable yields exactly one result.
  - in_data changes after the latch are ignored.

Decomposition:
- Package graying_pkg holds:
  - weights W_R=77, W_G=150, W_B=29 and the shift constant 8;
  - the work_mode encoding constants;
  - the FSM state typedef (IDLE, CALC, DONE).
- Sub-module graying_calc: the pipelined weighted sum with a valid shift chain, parameterised by color_width and mul_delay.
  - Used directly in mode 0.
  - In mode 1, driven by the FSM with a one-cycle valid pulse.
- The bench groups clk, rst_n, in_enable, in_data, out_ready and out_data in interface TBInterface, parameterised by color_width.

Test Plan:
- Mode 0, reset 10 cycles, then stream (255,255,255),(255,0,0),(0,255,0),(0,0,255) → out_data 255,76,149,28 on consecutive cycles, first result after edge n+1 (mul_delay=0); out_ready=0 during reset.
- Mode 0, pixel (100,150,200) then in_enable=0 for 2 cycles then (0,0,0) → 140, two out_ready=0 bubbles, then 0.
- Mode 1, request (100,150,200) held high → out_ready=1 with 140 after L+1 edges; held stable while in_enable=1; in_enable=0 → out_ready=0 next edge.
- Mode 1, in_data changed to (255,255,255) during CALC → result still 140. A second request after a one-cycle low gap returns 255.
- Mode 1, in_enable dropped mid-CALC → no out_ready pulse, FSM back in IDLE.
- Both modes, rst_n=1 asserted mid-stream or mid-CALC → out_ready=0, out_data=0 after that edge, no stale output after release.
- mul_delay=3 variant → latency grows by exactly 3 cycles, values unchanged.
